// File: rtl/ecc30_pkg.sv
// Shared 30/7 SECDED definitions: H-matrix data columns, parity function and
// injection encodings. The read-side checker imports the same package.
package ecc30_pkg;

  localparam int DATA_W = 30;
  localparam int PAR_W  = 7;
  localparam int CW_W   = DATA_W + PAR_W;
  localparam int POS_W  = 6;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10,
    INJ_NONE_3 = 2'b11
  } inj_mode_t;

  typedef enum logic {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_t;

  // Low six bits: ascending non-powers-of-two; bit 6 forces odd column weight.
  localparam logic [PAR_W-1:0] ECC30_H [DATA_W] = '{
    7'h43, 7'h45, 7'h46, 7'h07, 7'h49, 7'h4A, 7'h0B, 7'h4C, 7'h0D, 7'h0E,
    7'h4F, 7'h51, 7'h52, 7'h13, 7'h54, 7'h15, 7'h16, 7'h57, 7'h58, 7'h19,
    7'h1A, 7'h5B, 7'h1C, 7'h5D, 7'h5E, 7'h1F, 7'h61, 7'h62, 7'h23, 7'h64
  };

  function automatic logic [PAR_W-1:0] ecc30_parity(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) p = p ^ ECC30_H[i];
    end
    return p;
  endfunction

  // Codeword bit select; positions beyond the codeword select nothing.
  function automatic logic [CW_W-1:0] ecc30_onehot(input logic [POS_W-1:0] pos);
    logic [CW_W-1:0] m;
    m = '0;
    for (int i = 0; i < CW_W; i++) begin
      if (pos == POS_W'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ecc_30_enc_pipe_if.sv
// Stream bundle for the encoder: raw data in, codeword out.
interface ecc_30_enc_pipe_if;
  import ecc30_pkg::*;

  // Both streams: a beat transfers on a rising clk edge where valid & ready are
  // high; a producer holding valid must keep its payload stable until ready.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_parity;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_parity
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_parity
  );

endinterface

// File: rtl/ecc30_inj_ctrl.sv
// One-shot error injector: arms on request, produces the flip mask for the
// next word loaded into the output stage and pulses inj_done when it lands.
module ecc30_inj_ctrl
  import ecc30_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inj_en,
  input  logic [1:0]       inj_mode,
  input  logic [POS_W-1:0] inj_pos0,
  input  logic [POS_W-1:0] inj_pos1,
  input  logic             apply,
  output logic [CW_W-1:0]  flip_mask,
  output logic             inj_done,
  output inj_state_t       state
);

  inj_state_t       state_q, state_d;
  logic             double_q;
  logic [POS_W-1:0] pos0_q, pos1_q;
  logic             arm_req;
  logic             latch;
  logic             done_d;

  assign arm_req = inj_en && (inj_mode == INJ_SINGLE || inj_mode == INJ_DOUBLE);

  // While armed a new request is only taken on the apply cycle (re-arm).
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      INJ_IDLE: begin
        if (arm_req) begin
          state_d = INJ_ARMED;
          latch   = 1'b1;
        end
      end
      INJ_ARMED: begin
        if (apply) begin
          done_d = 1'b1;
          if (arm_req) latch = 1'b1;
          else         state_d = INJ_IDLE;
        end
      end
      default: state_d = INJ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= INJ_IDLE;
      double_q <= 1'b0;
      pos0_q   <= '0;
      pos1_q   <= '0;
      inj_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      inj_done <= done_d;
      if (latch) begin
        double_q <= (inj_mode == INJ_DOUBLE);
        pos0_q   <= inj_pos0;
        pos1_q   <= inj_pos1;
      end
    end
  end

  assign flip_mask = done_d ? (ecc30_onehot(pos0_q) ^ (double_q ? ecc30_onehot(pos1_q) : '0))
                            : '0;
  assign state = state_q;

endmodule

// File: rtl/ecc_30_enc_pipe.sv
// Write-side SECDED encoder: two-stage elastic pipeline (A: data, B: codeword)
// with one-shot error injection and a saturating transfer counter.
module ecc_30_enc_pipe
  import ecc30_pkg::*;
#(
  parameter int DATA_WIDTH   = 30,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ecc_30_enc_pipe_if.slave     bus,
  input  logic                 inj_en,
  input  logic [1:0]           inj_mode,
  input  logic [POS_W-1:0]     inj_pos0,
  input  logic [POS_W-1:0]     inj_pos1,
  output logic                 inj_done,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output inj_state_t           inj_state
);

  logic                    a_valid;
  logic [DATA_WIDTH-1:0]   a_data;
  logic                    b_valid;
  logic [DATA_WIDTH-1:0]   b_data;
  logic [PARITY_WIDTH-1:0] b_parity;
  logic                    b_load;
  logic                    apply;
  logic [CW_W-1:0]         flip_mask;
  logic [CW_W-1:0]         cw_next;

  // B takes whatever A holds whenever it can; A drains in the same cycle.
  assign b_load       = !b_valid || bus.out_ready;
  assign apply        = b_load && a_valid;
  assign bus.in_ready = !a_valid || b_load;

  // Injection acts on the finished codeword, so parity is never recomputed over flipped bits.
  assign cw_next = {ecc30_parity(a_data), a_data} ^ flip_mask;

  ecc30_inj_ctrl u_inj (
    .clk       (clk),
    .rst_n     (rst_n),
    .inj_en    (inj_en),
    .inj_mode  (inj_mode),
    .inj_pos0  (inj_pos0),
    .inj_pos1  (inj_pos1),
    .apply     (apply),
    .flip_mask (flip_mask),
    .inj_done  (inj_done),
    .state     (inj_state)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid  <= 1'b0;
      a_data   <= '0;
      b_valid  <= 1'b0;
      b_data   <= '0;
      b_parity <= '0;
      word_cnt <= '0;
    end else begin
      if (bus.in_ready) begin
        a_valid <= bus.in_valid;
        if (bus.in_valid) a_data <= bus.in_data;
      end
      if (b_load) begin
        b_valid <= a_valid;
        if (a_valid) {b_parity, b_data} <= cw_next;
      end
      if (b_valid && bus.out_ready && word_cnt != '1) word_cnt <= word_cnt + 1'b1;
    end
  end

  assign bus.out_valid  = b_valid;
  assign bus.out_data   = b_data;
  assign bus.out_parity = b_parity;

endmodule

// File: tb/tb_ecc_30_enc_pipe.sv
// Bench for ecc_30_enc_pipe: fixed parity vectors, random stream against a
// rule-derived SECDED model, stall, injection and mid-flight reset sequences.
module tb_ecc_30_enc_pipe;
  import ecc30_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inj_en = 1'b0;
  logic [1:0] inj_mode = 2'b00;
  logic [5:0] inj_pos0 = '0;
  logic [5:0] inj_pos1 = '0;
  logic       inj_done;
  logic [15:0] word_cnt;
  inj_state_t inj_state;

  always #5 clk = ~clk;

  ecc_30_enc_pipe_if bus ();

  ecc_30_enc_pipe #(.DATA_WIDTH(30), .PARITY_WIDTH(7), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .inj_en    (inj_en),
    .inj_mode  (inj_mode),
    .inj_pos0  (inj_pos0),
    .inj_pos1  (inj_pos1),
    .inj_done  (inj_done),
    .word_cnt  (word_cnt),
    .inj_state (inj_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];
  int ready_mode = 1;
  bit mon_en = 1'b1;
  int done_cnt = 0;
  int out_cnt = 0;
  logic        hold_v = 1'b0;
  logic [36:0] hold_cw, mon_cw, mon_exp;

  // ---------------- reference model (from the column rule) ----------------
  function automatic logic [6:0] ref_col(input int idx);
    int k;
    logic [5:0] v;
    k = 0;
    for (int n = 1; n < 64; n++) begin
      if ((n & (n - 1)) != 0) begin
        if (k == idx) begin
          v = 6'(n);
          return {($countones(v) % 2 == 0), v};
        end
        k++;
      end
    end
    return 7'h0;
  endfunction

  function automatic logic [6:0] ref_parity(input logic [29:0] d);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 30; i++) if (d[i]) p = p ^ ref_col(i);
    return p;
  endfunction

  function automatic logic [36:0] ref_cw(input logic [29:0] d);
    return {ref_parity(d), d};
  endfunction

  function automatic logic [36:0] ref_flip(input int pos);
    logic [36:0] m;
    m = '0;
    if (pos < 37) m[pos] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic drive_word(input logic [29:0] d, input logic [36:0] e);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!ok) check("in_ready_timeout", bus.in_ready, 1);
  endtask

  task automatic arm(input logic [1:0] mode, input int p0, input int p1);
    inj_en   = 1'b1;
    inj_mode = mode;
    inj_pos0 = 6'(p0);
    inj_pos1 = 6'(p1);
    step();
    inj_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    step();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      mon_cw = {bus.out_parity, bus.out_data};
      if (hold_v) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_hold", mon_cw, hold_cw);
      end
      if (inj_done) done_cnt++;
      if (mon_en && bus.out_valid && bus.out_ready) begin
        check("unexpected_word", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("codeword", mon_cw, mon_exp);
          check("syndrome", ref_parity(bus.out_data) ^ bus.out_parity,
                ref_parity(mon_exp[29:0]) ^ mon_exp[36:30]);
        end
        out_cnt++;
      end
      hold_v  = bus.out_valid && !bus.out_ready;
      hold_cw = mon_cw;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  typedef struct {
    logic [29:0] data;
    logic [6:0]  parity;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int lat, acc, done0, out0;
    logic [29:0] w[5];
    logic [29:0] d;

    tbl[0] = '{30'h0000_0001, 7'b1000011};
    tbl[1] = '{30'h2000_0000, 7'b1100100};
    tbl[2] = '{30'h3FFF_FFFF, 7'b0011011};
    tbl[3] = '{30'h0000_0000, 7'h00};
    tbl[4] = '{30'h0000_0002, 7'h45};
    tbl[5] = '{30'h0000_0003, 7'h06};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_parity", bus.out_parity, 0);
    check("rst_inj_done", inj_done, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_inj_state", inj_state, INJ_IDLE);
    step();

    // fixed vectors, first one also measures accept-to-valid latency
    drive_word(tbl[0].data, {tbl[0].parity, tbl[0].data});
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.out_valid) lat = k;
    end
    check("latency", lat, 2);
    step();
    for (int i = 1; i < 6; i++) drive_word(tbl[i].data, {tbl[i].parity, tbl[i].data});
    drain();

    // random stream with random backpressure
    pulse_reset();
    ready_mode = 2;
    out0 = out_cnt;
    for (int i = 0; i < 1000; i++) begin
      d = 30'($urandom());
      drive_word(d, ref_cw(d));
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
    ready_mode = 1;
    @(negedge clk);
    check("rand_delivered", out_cnt - out0, 1000);
    check("rand_word_cnt", word_cnt, 1000);
    step();

    // stall: 5 words offered while downstream blocked for 10 cycles
    ready_mode = 0;
    step();
    step();
    for (int i = 0; i < 5; i++) w[i] = 30'($urandom());
    acc = 0;
    out0 = out_cnt;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (acc < 5);
      bus.in_data  = w[acc < 5 ? acc : 4];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_cw(w[acc]));
        acc++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stall_accepted", acc, 2);
    check("stall_in_ready", bus.in_ready, 0);
    step();
    ready_mode = 1;
    for (int i = 2; i < 5; i++) drive_word(w[i], ref_cw(w[i]));
    drain();
    check("stall_delivered", out_cnt - out0, 5);

    // single injection at bit 5, then a clean word
    done0 = done_cnt;
    arm(2'b01, 5, 0);
    drive_word(30'h0, ref_cw(30'h0) ^ ref_flip(5));
    drive_word(30'h0, ref_cw(30'h0));
    drain();
    check("single_done_pulses", done_cnt - done0, 1);
    check("single_state_idle", inj_state, INJ_IDLE);

    // double injection, cancelling double, out-of-range single
    done0 = done_cnt;
    arm(2'b10, 0, 1);
    drive_word(30'h0, ref_cw(30'h0) ^ ref_flip(0) ^ ref_flip(1));
    drain();
    arm(2'b10, 7, 7);
    drive_word(30'h0, ref_cw(30'h0));
    drain();
    d = 30'($urandom());
    arm(2'b01, 40, 0);
    drive_word(d, ref_cw(d));
    drain();
    check("double_done_pulses", done_cnt - done0, 3);

    // re-arm on the apply cycle (parity bit 33 on the second word)
    done0 = done_cnt;
    arm(2'b01, 2, 0);
    drive_word(30'h0, ref_cw(30'h0) ^ ref_flip(2));
    arm(2'b01, 33, 0);
    drive_word(30'h0, ref_cw(30'h0) ^ ref_flip(33));
    drive_word(30'h0, ref_cw(30'h0));
    drain();
    check("rearm_done_pulses", done_cnt - done0, 2);

    // reset with both stages full and the injector armed
    ready_mode = 0;
    mon_en = 1'b0;
    step();
    step();
    drive_word(30'h1234, 37'h0);
    drive_word(30'h5678, 37'h0);
    arm(2'b01, 3, 0);
    @(negedge clk);
    check("pre_rst_armed", inj_state, INJ_ARMED);
    check("pre_rst_full", bus.in_ready, 0);
    step();
    exp_q.delete();
    pulse_reset();
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_word_cnt", word_cnt, 0);
    check("mid_rst_state", inj_state, INJ_IDLE);
    step();
    ready_mode = 1;
    mon_en = 1'b1;
    done0 = done_cnt;
    d = 30'($urandom());
    step();
    drive_word(d, ref_cw(d));
    drain();
    check("post_rst_no_inject", done_cnt - done0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
